// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM states, ALU function codes,
// flag bit positions and the latched request record.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLAG  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [4:0] FUN_ADD16 = 5'b00100;
  localparam logic [4:0] FUN_ADC16 = 5'b00101;
  localparam logic [4:0] FUN_ADD32 = 5'b10100;
  localparam logic [4:0] FUN_ADC32 = 5'b10101;
  localparam logic [4:0] FUN_SUB32 = 5'b10110;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef struct packed {
    logic [4:0]  funSel;
    logic [31:0] a;
    logic [31:0] b;
    logic        wf;
    logic        lock;
  } alu_req_t;

endpackage

// File: rtl/rr_lock_picker.sv
// Combinational winner selection between two requesters: an unexpired lock
// owner that is requesting wins, otherwise round-robin pointer first.
module rr_lock_picker (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  input  logic       lockHeld_i,
  input  logic       lockOwner_i,
  input  logic       lockExpired_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = ptr_i;
    if (lockHeld_i && !lockExpired_i && valid_i[lockOwner_i]) begin
      winner_o = lockOwner_i;
    end else if (valid_i[ptr_i]) begin
      winner_o = ptr_i;
    end else begin
      winner_o = ~ptr_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant with an optional
// bounded lock, then a fixed ISSUE -> FLAG -> RESP sequence per operation.
module alu_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req0Valid,
  input  logic        Req1Valid,
  output logic        Req0Ready,
  output logic        Req1Ready,
  input  logic [4:0]  Req0FunSel,
  input  logic [4:0]  Req1FunSel,
  input  logic [31:0] Req0A,
  input  logic [31:0] Req0B,
  input  logic [31:0] Req1A,
  input  logic [31:0] Req1B,
  input  logic        Req0WF,
  input  logic        Req1WF,
  input  logic        Req0Lock,
  input  logic        Req1Lock,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [4:0]  AluFunSel,
  output logic        AluWF,
  input  logic [31:0] AluOut,
  input  logic [3:0]  AluFlags,
  output logic        RspValid,
  input  logic        RspReady,
  output logic        RspId,
  output logic [31:0] RspResult,
  output logic [3:0]  RspFlags
);
  import alu_pkg::*;

  localparam int CntW = $clog2(LOCK_MAX + 1);

  arb_state_e      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            lockHeld_q, lockHeld_d;
  logic            lockOwner_q, lockOwner_d;
  logic [CntW-1:0] lockCnt_q, lockCnt_d;
  logic [31:0]     aluA_q, aluB_q, rspResult_q;
  logic [4:0]      funSel_q;
  logic            wf_q, id_q;
  logic [3:0]      rspFlags_q;

  logic [1:0]      reqValid;
  logic            winner, lockExpired, grant;
  alu_req_t        req0, req1, selReq;

  assign reqValid    = {Req1Valid, Req0Valid};
  assign req0        = {Req0FunSel, Req0A, Req0B, Req0WF, Req0Lock};
  assign req1        = {Req1FunSel, Req1A, Req1B, Req1WF, Req1Lock};
  assign selReq      = winner ? req1 : req0;
  assign lockExpired = lockCnt_q >= CntW'(LOCK_MAX);
  assign grant       = (state_q == IDLE) && (|reqValid);

  rr_lock_picker uPicker (
    .valid_i       (reqValid),
    .ptr_i         (ptr_q),
    .lockHeld_i    (lockHeld_q),
    .lockOwner_i   (lockOwner_q),
    .lockExpired_i (lockExpired),
    .winner_o      (winner)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lockHeld_d  = lockHeld_q;
    lockOwner_d = lockOwner_q;
    lockCnt_d   = lockCnt_q;
    case (state_q)
      IDLE: begin
        // An owner that stops requesting gives up the lock.
        if (lockHeld_q && !reqValid[lockOwner_q]) begin
          lockHeld_d = 1'b0;
          lockCnt_d  = '0;
        end
        if (grant) begin
          state_d = ISSUE;
          ptr_d   = ~winner;
          if (selReq.lock) begin
            lockHeld_d  = 1'b1;
            lockOwner_d = winner;
            if (lockHeld_q && (lockOwner_q == winner) && !lockExpired) begin
              lockCnt_d = lockCnt_q + CntW'(1);
            end else begin
              lockCnt_d = CntW'(1);
            end
          end else if (lockExpired || (lockHeld_q && (lockOwner_q == winner))) begin
            lockHeld_d = 1'b0;
            lockCnt_d  = '0;
          end
        end
      end
      ISSUE:   state_d = FLAG;
      FLAG:    state_d = RESP;
      RESP:    if (RspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      lockHeld_q  <= 1'b0;
      lockOwner_q <= 1'b0;
      lockCnt_q   <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      funSel_q    <= '0;
      wf_q        <= 1'b0;
      id_q        <= 1'b0;
      rspResult_q <= '0;
      rspFlags_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lockHeld_q  <= lockHeld_d;
      lockOwner_q <= lockOwner_d;
      lockCnt_q   <= lockCnt_d;
      // Operands load at grant so they are on the ALU throughout ISSUE.
      if (grant) begin
        aluA_q   <= selReq.a;
        aluB_q   <= selReq.b;
        funSel_q <= selReq.funSel;
        wf_q     <= selReq.wf;
        id_q     <= winner;
      end
      if (state_q == ISSUE) rspResult_q <= AluOut;
      if (state_q == FLAG)  rspFlags_q  <= AluFlags;
    end
  end

  assign Req0Ready = grant & ~winner;
  assign Req1Ready = grant & winner;
  assign AluA      = aluA_q;
  assign AluB      = aluB_q;
  assign AluFunSel = funSel_q;
  assign AluWF     = (state_q == ISSUE) & wf_q;
  assign RspValid  = (state_q == RESP);
  assign RspId     = id_q;
  assign RspResult = rspResult_q;
  assign RspFlags  = rspFlags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU (result plus
// registered {Z,C,N,O} flags) and queue-driven requesters.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int LockMax = 2;

  logic        Clock, Reset;
  logic        Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [4:0]  Req0FunSel, Req1FunSel, AluFunSel;
  logic [31:0] Req0A, Req0B, Req1A, Req1B, AluA, AluB, AluOut, RspResult;
  logic        Req0WF, Req1WF, Req0Lock, Req1Lock, AluWF;
  logic        RspValid, RspReady, RspId;
  logic [3:0]  AluFlags, RspFlags;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic [3:0]  flags;
  } rsp_t;

  alu_req_t reqQ0[$];
  alu_req_t reqQ1[$];
  rsp_t     expRsp[$];
  logic     expGrant[$];

  int   checks = 0;
  int   passes = 0;
  int   cycle = 0;
  bit   spacingCheck = 0;

  logic [3:0]  aluFlagsQ, nextFlags;
  logic [32:0] sum;
  logic        cin;

  alu_arbiter #(.LOCK_MAX(LockMax)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .Req0FunSel(Req0FunSel), .Req1FunSel(Req1FunSel),
    .Req0A(Req0A), .Req0B(Req0B), .Req1A(Req1A), .Req1B(Req1B),
    .Req0WF(Req0WF), .Req1WF(Req1WF), .Req0Lock(Req0Lock), .Req1Lock(Req1Lock),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .RspResult(RspResult), .RspFlags(RspFlags)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cycle <= cycle + 1;

  // Behavioural ALU: 16-bit ops produce a zero-extended result.
  always_comb begin
    cin       = ((AluFunSel == FUN_ADC16) || (AluFunSel == FUN_ADC32)) ? aluFlagsQ[FLAG_C] : 1'b0;
    sum       = '0;
    AluOut    = AluA;
    nextFlags = aluFlagsQ;
    if ((AluFunSel == FUN_ADD16) || (AluFunSel == FUN_ADC16)) begin
      sum               = {17'b0, AluA[15:0]} + {17'b0, AluB[15:0]} + {32'b0, cin};
      AluOut            = {16'b0, sum[15:0]};
      nextFlags[FLAG_Z] = (sum[15:0] == 16'h0);
      nextFlags[FLAG_C] = sum[16];
      nextFlags[FLAG_N] = sum[15];
      nextFlags[FLAG_O] = (AluA[15] == AluB[15]) && (sum[15] != AluA[15]);
    end else if ((AluFunSel == FUN_ADD32) || (AluFunSel == FUN_ADC32) || (AluFunSel == FUN_SUB32)) begin
      if (AluFunSel == FUN_SUB32) sum = {1'b0, AluA} + {1'b0, ~AluB} + 33'd1;
      else                        sum = {1'b0, AluA} + {1'b0, AluB} + {32'b0, cin};
      AluOut            = sum[31:0];
      nextFlags[FLAG_Z] = (sum[31:0] == 32'h0);
      nextFlags[FLAG_C] = sum[32];
      nextFlags[FLAG_N] = sum[31];
      if (AluFunSel == FUN_SUB32) nextFlags[FLAG_O] = (AluA[31] != AluB[31]) && (sum[31] != AluA[31]);
      else                        nextFlags[FLAG_O] = (AluA[31] == AluB[31]) && (sum[31] != AluA[31]);
    end
  end

  always @(posedge Clock or negedge Reset) begin
    if (!Reset)     aluFlagsQ <= 4'b0000;
    else if (AluWF) aluFlagsQ <= nextFlags;
  end
  assign AluFlags = aluFlagsQ;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int who, input logic [4:0] fun, input logic [31:0] a,
                               input logic [31:0] b, input logic wf, input logic lock);
    alu_req_t r;
    r = {fun, a, b, wf, lock};
    if (who == 0) reqQ0.push_back(r);
    else          reqQ1.push_back(r);
  endtask

  task automatic expectOp(input logic id, input logic [31:0] result, input logic [3:0] flags);
    rsp_t e;
    e = {id, result, flags};
    expGrant.push_back(id);
    expRsp.push_back(e);
  endtask

  task automatic applyReset(input bit checkValues);
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    if (checkValues) begin
      checkOutput("reset_AluA", 64'(AluA), 64'(0));
      checkOutput("reset_AluB", 64'(AluB), 64'(0));
      checkOutput("reset_AluFunSel", 64'(AluFunSel), 64'(0));
      checkOutput("reset_AluWF", 64'(AluWF), 64'(0));
      checkOutput("reset_RspValid", 64'(RspValid), 64'(0));
      checkOutput("reset_RspId_Result_Flags", 64'({RspId, RspResult, RspFlags}), 64'(0));
      checkOutput("reset_Ready", 64'({Req0Ready, Req1Ready}), 64'(0));
    end
    Reset = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (((reqQ0.size() + reqQ1.size() + expRsp.size() + expGrant.size()) != 0) && (n < 300)) begin
      @(posedge Clock);
      n++;
    end
    repeat (2) @(posedge Clock);
    #1;
    checkOutput(name, 64'(expRsp.size() + expGrant.size() + reqQ0.size() + reqQ1.size()), 64'(0));
  endtask

  // Requester model: present queue heads, retire an entry when it is granted.
  initial begin
    Req0Valid = 1'b0; Req0FunSel = '0; Req0A = '0; Req0B = '0; Req0WF = 1'b0; Req0Lock = 1'b0;
    Req1Valid = 1'b0; Req1FunSel = '0; Req1A = '0; Req1B = '0; Req1WF = 1'b0; Req1Lock = 1'b0;
    forever begin
      @(negedge Clock);
      if (Req0Ready && (reqQ0.size() > 0)) reqQ0.delete(0);
      if (Req1Ready && (reqQ1.size() > 0)) reqQ1.delete(0);
      @(posedge Clock);
      #1;
      Req0Valid = (reqQ0.size() > 0);
      if (reqQ0.size() > 0) {Req0FunSel, Req0A, Req0B, Req0WF, Req0Lock} = reqQ0[0];
      Req1Valid = (reqQ1.size() > 0);
      if (reqQ1.size() > 0) {Req1FunSel, Req1A, Req1B, Req1WF, Req1Lock} = reqQ1[0];
    end
  end

  // Monitor: grant order/spacing, response latency and response contents.
  initial begin
    int   lastGrantCycle = 0;
    int   spacingRef = -1;
    bit   prevRspValid = 1'b0;
    logic gid;
    rsp_t e;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        prevRspValid = 1'b0;
        spacingRef   = -1;
      end else begin
        if (Req0Ready || Req1Ready) begin
          checks++;
          if (expGrant.size() == 0) begin
            $display("[TB] FAIL grant_unexpected: got grant to requester %0d, required no grant", Req1Ready);
          end else begin
            gid = expGrant.pop_front();
            if ((Req1Ready === gid) && (Req0Ready !== Req1Ready)) passes++;
            else $display("[TB] FAIL grant_id: got Req0Ready=%0b Req1Ready=%0b, required grant to requester %0d",
                          Req0Ready, Req1Ready, gid);
          end
          if (spacingCheck) begin
            if (spacingRef >= 0) checkOutput("grant_spacing", 64'(cycle - spacingRef), 64'(4));
            spacingRef = cycle;
          end else begin
            spacingRef = -1;
          end
          lastGrantCycle = cycle;
        end
        if (RspValid && !prevRspValid) checkOutput("rsp_latency", 64'(cycle - lastGrantCycle), 64'(3));
        if (RspValid && RspReady) begin
          if (expRsp.size() == 0) begin
            checks++;
            $display("[TB] FAIL rsp_unexpected: got response id %0d result 0x%0h, required none", RspId, RspResult);
          end else begin
            e = expRsp.pop_front();
            checkOutput("rsp_id", 64'(RspId), 64'(e.id));
            checkOutput("rsp_result", 64'(RspResult), 64'(e.result));
            checkOutput("rsp_flags", 64'(RspFlags), 64'(e.flags));
          end
        end
        prevRspValid = RspValid;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, required $finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    Reset    = 1'b0;
    RspReady = 1'b1;
    applyReset(1'b1);

    // Single 16-bit add that wraps to zero.
    applyStimulus(0, FUN_ADD16, 32'h0000FFFF, 32'h00000001, 1'b1, 1'b0);
    expectOp(1'b0, 32'h00000000, 4'b1100);
    waitDrain("drain_single");

    // Contention: both always valid, alternating grants four cycles apart.
    applyReset(1'b0);
    spacingCheck = 1'b1;
    applyStimulus(0, FUN_ADD16, 32'h00001234, 32'h00001111, 1'b0, 1'b0);
    applyStimulus(0, FUN_ADD16, 32'h00008000, 32'h00008000, 1'b0, 1'b0);
    applyStimulus(1, FUN_ADD32, 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0);
    applyStimulus(1, FUN_ADC32, 32'h00000010, 32'h00000020, 1'b1, 1'b0);
    expectOp(1'b0, 32'h00002345, 4'b0000);
    expectOp(1'b1, 32'h00000001, 4'b0100);
    expectOp(1'b0, 32'h00000000, 4'b0100);
    expectOp(1'b1, 32'h00000031, 4'b0000);
    waitDrain("drain_contention");
    spacingCheck = 1'b0;

    // Locked carry chain keeps Req1 out between ADD32 and ADC32.
    applyReset(1'b0);
    applyStimulus(0, FUN_ADD32, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1);
    applyStimulus(0, FUN_ADC32, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    applyStimulus(1, FUN_ADD32, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
    expectOp(1'b0, 32'h00000000, 4'b1100);
    expectOp(1'b0, 32'h00000001, 4'b0000);
    expectOp(1'b1, 32'h80000000, 4'b0011);
    waitDrain("drain_lock_chain");

    // Starvation guard: lock expires after LockMax locked grants.
    applyReset(1'b0);
    applyStimulus(0, FUN_ADD32, 32'h1, 32'h1, 1'b0, 1'b1);
    applyStimulus(0, FUN_ADD32, 32'h2, 32'h1, 1'b0, 1'b1);
    applyStimulus(0, FUN_ADD32, 32'h3, 32'h1, 1'b0, 1'b1);
    applyStimulus(1, FUN_ADD32, 32'h10, 32'h1, 1'b0, 1'b0);
    expectOp(1'b0, 32'h00000002, 4'b0000);
    expectOp(1'b0, 32'h00000003, 4'b0000);
    expectOp(1'b1, 32'h00000011, 4'b0000);
    expectOp(1'b0, 32'h00000004, 4'b0000);
    waitDrain("drain_starvation");

    // Backpressure: response held, no grant until accepted.
    applyReset(1'b0);
    RspReady = 1'b0;
    applyStimulus(0, FUN_ADD32, 32'h00000100, 32'h00000023, 1'b0, 1'b0);
    applyStimulus(1, FUN_ADD32, 32'h00000005, 32'h00000006, 1'b0, 1'b0);
    expectOp(1'b0, 32'h00000123, 4'b0000);
    expectOp(1'b1, 32'h0000000B, 4'b0000);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!RspValid && (n < 20));
    checkOutput("bp_rsp_seen", 64'(RspValid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clock);
      checkOutput("bp_hold", 64'({RspValid, RspId, Req0Ready, Req1Ready, RspFlags, RspResult}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h00000123}));
    end
    @(posedge Clock);
    #1;
    RspReady = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("bp_grant_after_accept", 64'(Req1Ready), 64'(1));
    waitDrain("drain_backpressure");

    // Reset during FLAG drops the operation; Req1 then completes normally.
    applyReset(1'b0);
    applyStimulus(0, FUN_ADD32, 32'h00000001, 32'h00000002, 1'b1, 1'b0);
    expGrant.push_back(1'b0);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!Req0Ready && (n < 20));
    checkOutput("rst_test_grant", 64'(Req0Ready), 64'(1));
    @(posedge Clock);
    @(posedge Clock);
    #2;
    checkOutput("rst_pre_result", 64'(RspResult), 64'(3));
    Reset = 1'b0;
    #1;
    checkOutput("rst_AluWF", 64'(AluWF), 64'(0));
    checkOutput("rst_RspValid", 64'(RspValid), 64'(0));
    checkOutput("rst_RspResult", 64'(RspResult), 64'(0));
    checkOutput("rst_AluA", 64'(AluA), 64'(0));
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    applyStimulus(1, FUN_ADD16, 32'h00000001, 32'h00000002, 1'b1, 1'b0);
    expectOp(1'b1, 32'h00000003, 4'b0000);
    waitDrain("drain_after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `ArithmeticLogicUnit` between two requesters, for example the instruction sequencer and an address-generation path. It runs round-robin arbitration over a valid/ready request interface and drives the ALU operands, function select and flag-write strobe. It returns the ALU result together with the post-operation flags on a valid/ready response interface. A lock mechanism lets one requester keep the ALU across back-to-back operations, so that carry-chained sequences (ADD then ADC) are not interleaved with the other requester's flag writes.

## Interface
- `LOCK_MAX`, default 8: maximum consecutive locked grants to one requester before the lock is force-released.
- `Clock` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Req0Valid`, `Req1Valid` in 1: request present.
- `Req0Ready`, `Req1Ready` out 1: one-cycle grant/accept pulse.
- `Req0FunSel`, `Req1FunSel` in 5: ALU function code.
- `Req0A`, `Req0B`, `Req1A`, `Req1B` in 32: operands.
- `Req0WF`, `Req1WF` in 1: update the ALU flag register.
- `Req0Lock`, `Req1Lock` in 1: request to keep priority for this requester's next request.
- `AluA`, `AluB` out 32: ALU operands.
- `AluFunSel` out 5: ALU function select.
- `AluWF` out 1: ALU flag-write enable.
- `AluOut` in 32: ALU combinational result.
- `AluFlags` in 4: ALU registered flags {Z,C,N,O}.
- `RspValid` out 1: response present.
- `RspReady` in 1: response accepted.
- `RspId` out 1: requester the response belongs to (0/1).
- `RspResult` out 32: captured ALU result.
- `RspFlags` out 4: flags after the operation ({Z,C,N,O}).

## Operation
- FSM states: IDLE, ISSUE, FLAG, RESP.
- **IDLE**
  - If any ReqValid, select a winner, pulse its ReqReady, latch FunSel/A/B/WF/Lock/id, and go to ISSUE.
  - If no ReqValid, stay in IDLE.
- **Winner selection**
  - If a lock is held and the lock owner's ReqValid is high, the owner wins.
  - Otherwise the requester indicated by the round-robin pointer wins if valid, else the other one.
  - The pointer moves to the non-winner after every grant.
- **ISSUE**
  - Drive AluA/AluB/AluFunSel from the latched request and AluWF = latched WF for this cycle only.
  - Capture AluOut into RspResult.
  - Go to FLAG.
- **FLAG**
  - AluWF = 0. Capture AluFlags, already updated by the ISSUE edge, into RspFlags.
  - Go to RESP.
- **RESP**
  - RspValid = 1, with RspId/RspResult/RspFlags stable.
  - On RspValid & RspReady, go to IDLE.
- **Lock**
  - Set on grant if the latched Lock = 1; the owner is the winner.
  - Cleared when any of the following happens:
    - the owner is granted with Lock = 0;
    - the owner's ReqValid is low while in IDLE;
    - the consecutive locked-grant count reaches LOCK_MAX, in which case the next arbitration ignores the lock and the counter resets to 0.
- **Outputs outside ISSUE**
  - AluA/AluB/AluFunSel hold their last driven values.
  - AluWF = 0 in every state except ISSUE.
- **Reset values**
  - State IDLE, all Ready/RspValid/AluWF = 0.
  - AluA/AluB/RspResult = 0, AluFunSel = 0, RspFlags = 0, RspId = 0.
  - Pointer = requester 0, lock cleared, lock counter 0.

## Timing
- Grant-to-response latency: ReqReady in cycle t, ISSUE in t+1, FLAG in t+2, RspValid from t+3.
- Minimum spacing is 4 cycles per operation. RspValid holds indefinitely under backpressure, and no new grant is made until the response is accepted.
- ReqReady is high for exactly one cycle. The requester must hold its fields stable only during that cycle.
- Both requesters valid, no lock: requesters alternate grants.
- When WF = 0, RspFlags reflects the unchanged ALU flag register.
- Reset asserted mid-operation: outputs return to reset values asynchronously, the in-flight operation is dropped, and no response is issued.

## Structure
- Shared package `alu_pkg` holds:
  - state encoding constants (IDLE/ISSUE/FLAG/RESP);
  - the ALU FunSel codes (e.g. ADD16 = 5'b00100, ADC16 = 5'b00101, ADD32 = 5'b10100, ADC32 = 5'b10101, SUB32 = 5'b10110);
  - flag bit indices (Z = 3, C = 2, N = 1, O = 0).
- One natural sub-module, `rr_lock_picker`, which is combinational winner selection from the valid bits, pointer, lock owner and lock-expired input.
- The FSM, latches and lock counter stay in `alu_arbiter`.

## Test plan
- **Single request, 16-bit add:** Req0 FunSel = 00100, A = 0x0000FFFF, B = 0x00000001, WF = 1. Required response: RspValid at t+3, RspId = 0, RspResult = 0x00000000, RspFlags = 4'b1100.
- **Contention:** both requesters valid continuously, no lock, RspReady = 1. Required: grants alternate 0, 1, 0, 1, spaced 4 cycles apart.
- **Locked carry chain:**
  - Req0 sends ADD32 0xFFFFFFFF + 0x1 with Lock = 1, then ADC32 0x0 + 0x0 with Lock = 0, while Req1 is valid throughout.
  - Required: both Req0 operations are granted consecutively; the second RspResult = 0x00000001; Req1 is granted next.
- **Lock starvation guard:** LOCK_MAX = 2, Req0 always Lock = 1, Req1 valid. Required: Req1 is granted after the 2nd locked Req0 grant.
- **Backpressure:** RspReady held low for 5 cycles. Required: RspValid/RspResult remain stable, no ReqReady is issued, and a grant follows in the cycle after acceptance.
- **Reset in FLAG state:** Reset asserted low during FLAG. Required: AluWF = 0 and RspValid = 0 immediately; after release, the next Req1 request completes normally.
